// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: memory DataType codes, FSM states
// and the fixed request-to-response latencies.
package lsu_pkg;

    localparam logic [1:0] DT_WORD = 2'b00;
    localparam logic [1:0] DT_BYTE = 2'b01;
    localparam logic [1:0] DT_HALF = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsuState_t;

    localparam int unsigned LOAD_LAT  = 3;
    localparam int unsigned STORE_LAT = 2;

    // The memory only knows byte/half/word; size 11 is an alias for word.
    function automatic logic [1:0] toDataType(input logic [1:0] size);
        return (size == 2'b11) ? DT_WORD : size;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Zero/sign extension of the memory's low-aligned read data to a full word.
module load_formatter
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            size,
    input  logic                  signExt,
    input  logic [DATA_WIDTH-1:0] memData,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = memData;
        case (toDataType(size))
            DT_BYTE: result = {{(DATA_WIDTH-8){signExt & memData[7]}}, memData[7:0]};
            DT_HALF: result = {{(DATA_WIDTH-16){signExt & memData[15]}}, memData[15:0]};
            default: result = memData;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for the byte-banked data memory.
// Strobes and memory-side buses are registered from the next-state decode.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    output logic                  req_ready,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  EscMen,
    output logic                  ReadMen,
    output logic [1:0]            DataType,
    input  logic [DATA_WIDTH-1:0] saida_mem
);

    lsuState_t state, stateNext;

    logic                  reqWe;
    logic                  reqSignExt;
    logic [1:0]            reqSize;
    logic [ADDR_WIDTH-1:0] reqAddr;
    logic [DATA_WIDTH-1:0] reqWdata;

    logic                  escNext;
    logic                  readNext;
    logic [ADDR_WIDTH-1:0] addrNext;
    logic [DATA_WIDTH-1:0] dataNext;
    logic [1:0]            dtNext;
    logic [DATA_WIDTH-1:0] formatted;
    logic                  accept;

    assign req_ready = (state == IDLE);
    assign accept    = req && req_ready;

    // Outputs for ISSUE come straight from the inputs because the request
    // registers load on the same edge that enters ISSUE.
    always_comb begin
        stateNext = state;
        escNext   = 1'b0;
        readNext  = 1'b0;
        addrNext  = '0;
        dataNext  = '0;
        dtNext    = DT_WORD;
        unique case (state)
            IDLE: begin
                if (req) begin
                    stateNext = ISSUE;
                    escNext   = we;
                    readNext  = !we;
                    addrNext  = addr_in;
                    dataNext  = wdata_in;
                    dtNext    = toDataType(size);
                end
            end
            ISSUE: begin
                if (reqWe) begin
                    stateNext = RESP;
                end else begin
                    stateNext = WAIT;
                    readNext  = 1'b1;
                    addrNext  = reqAddr;
                    dataNext  = reqWdata;
                    dtNext    = toDataType(reqSize);
                end
            end
            WAIT:    stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            EscMen    <= 1'b0;
            ReadMen   <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            DataType  <= DT_WORD;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            EscMen    <= escNext;
            ReadMen   <= readNext;
            mem_addr  <= addrNext;
            mem_data  <= dataNext;
            DataType  <= dtNext;
            rsp_valid <= (stateNext == RESP);
            if (state == WAIT) begin
                rsp_data <= formatted;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reqWe      <= 1'b0;
            reqSignExt <= 1'b0;
            reqSize    <= 2'b00;
            reqAddr    <= '0;
            reqWdata   <= '0;
        end else if (accept) begin
            reqWe      <= we;
            reqSignExt <= sign_ext;
            reqSize    <= size;
            reqAddr    <= addr_in;
            reqWdata   <= wdata_in;
        end
    end

    load_formatter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) uFormatter (
        .size    (reqSize),
        .signExt (reqSignExt),
        .memData (saida_mem),
        .result  (formatted)
    );

endmodule
